imager_crop: RTL and testbench

- Region-of-interest crop stage directly downstream of the imager receive block.
- Consumes the typed pixel stream (dvi/dtypei/datai) and forwards only pixels and row markers inside a programmable window.
- Frame markers and header words pass through unchanged.
- Output uses the same stream format, so the stage can be inserted or removed in the pipeline transparently.

---
 rtl/imager_crop.sv | 149 ++++++++++++++
 tb/tb_imager_crop.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imager_crop.sv
// Region-of-interest crop for the typed imager pixel stream. Frame markers and
// header words pass through; pixels and row markers are kept only inside the window.
`ifndef IMAGER_DTYPES
`define IMAGER_DTYPES
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'd1
`define DTYPE_FRAME_END    4'd2
`define DTYPE_ROW_START    4'd3
`define DTYPE_ROW_END      4'd4
`define DTYPE_PIXEL        4'd5
`define DTYPE_HEADER_START 4'd6
`define DTYPE_HEADER       4'd7
`define DTYPE_HEADER_END   4'd8
`endif

module imager_crop #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DIM_WIDTH-1:0]    win_x0,
    input  logic [DIM_WIDTH-1:0]    win_y0,
    input  logic [DIM_WIDTH-1:0]    win_width,
    input  logic [DIM_WIDTH-1:0]    win_height,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic [DIM_WIDTH-1:0]    crop_rows,
    output logic [DIM_WIDTH-1:0]    crop_cols
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_reg;
    logic                  en_reg;
    logic [DIM_WIDTH-1:0]  x0_reg, y0_reg, w_reg, h_reg;
    logic [DIM_WIDTH-1:0]  row_cnt_reg, col_cnt_reg;
    logic [DIM_WIDTH-1:0]  out_row_reg, out_col_reg, last_out_cols_reg;

    logic [DIM_WIDTH:0]    x_end, y_end;
    logic [DIM_WIDTH-1:0]  row_off;
    logic                  row_in, col_in, active;
    logic                  keep;
    logic [DATA_WIDTH-1:0] keep_data;

    function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
        return (&v) ? v : v + {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Window ends carry one extra bit so a window reaching past all-ones cannot wrap to 0.
    assign x_end   = {1'b0, x0_reg} + {1'b0, w_reg};
    assign y_end   = {1'b0, y0_reg} + {1'b0, h_reg};
    assign row_off = row_cnt_reg - y0_reg;
    assign active  = (state_reg == ACTIVE);
    // A zero-width window suppresses row markers too, leaving only the frame markers.
    assign row_in  = (row_cnt_reg >= y0_reg) && ({1'b0, row_cnt_reg} < y_end) && (w_reg != '0);
    assign col_in  = (col_cnt_reg >= x0_reg) && ({1'b0, col_cnt_reg} < x_end);

    always_comb begin
        keep      = 1'b0;
        keep_data = datai;
        if (dvi) begin
            case (dtypei)
                `DTYPE_FRAME_START: keep = 1'b1;
                `DTYPE_FRAME_END:   keep = active;
                `DTYPE_ROW_START: begin
                    keep = active && (!en_reg || row_in);
                    if (en_reg) keep_data = DATA_WIDTH'(row_off);
                end
                `DTYPE_ROW_END:     keep = active && (!en_reg || row_in);
                `DTYPE_PIXEL:       keep = active && (!en_reg || (row_in && col_in));
                default:            keep = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            en_reg            <= 1'b0;
            x0_reg            <= '0;
            y0_reg            <= '0;
            w_reg             <= '0;
            h_reg             <= '0;
            row_cnt_reg       <= '0;
            col_cnt_reg       <= '0;
            out_row_reg       <= '0;
            out_col_reg       <= '0;
            last_out_cols_reg <= '0;
            dvo               <= 1'b0;
            dtypeo            <= '0;
            datao             <= '0;
            crop_rows         <= '0;
            crop_cols         <= '0;
        end else begin
            dvo    <= keep;
            dtypeo <= keep ? dtypei : '0;
            datao  <= keep ? keep_data : '0;
            if (dvi) begin
                if (dtypei == `DTYPE_FRAME_START) begin
                    // Also taken in ACTIVE, which recovers from a lost FRAME_END.
                    state_reg         <= ACTIVE;
                    en_reg            <= enable;
                    x0_reg            <= win_x0;
                    y0_reg            <= win_y0;
                    w_reg             <= win_width;
                    h_reg             <= win_height;
                    row_cnt_reg       <= '0;
                    col_cnt_reg       <= '0;
                    out_row_reg       <= '0;
                    out_col_reg       <= '0;
                    last_out_cols_reg <= '0;
                end else if (active) begin
                    case (dtypei)
                        `DTYPE_FRAME_END: begin
                            crop_rows <= out_row_reg;
                            crop_cols <= last_out_cols_reg;
                            state_reg <= IDLE;
                        end
                        `DTYPE_ROW_START: begin
                            col_cnt_reg <= '0;
                            out_col_reg <= '0;
                        end
                        `DTYPE_ROW_END: begin
                            col_cnt_reg <= '0;
                            out_col_reg <= '0;
                            row_cnt_reg <= sat_inc(row_cnt_reg);
                            if (keep) begin
                                out_row_reg       <= sat_inc(out_row_reg);
                                last_out_cols_reg <= out_col_reg;
                            end
                        end
                        `DTYPE_PIXEL: begin
                            col_cnt_reg <= sat_inc(col_cnt_reg);
                            if (keep) out_col_reg <= sat_inc(out_col_reg);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_imager_crop.sv
// Bench for imager_crop: frames are described at the row/column level and the
// expected output stream and crop counts are derived from the window rules.
`timescale 1ns/1ps
`ifndef IMAGER_DTYPES
`define IMAGER_DTYPES
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'd1
`define DTYPE_FRAME_END    4'd2
`define DTYPE_ROW_START    4'd3
`define DTYPE_ROW_END      4'd4
`define DTYPE_PIXEL        4'd5
`define DTYPE_HEADER_START 4'd6
`define DTYPE_HEADER       4'd7
`define DTYPE_HEADER_END   4'd8
`endif

module tb_imager_crop;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] win_x0, win_y0, win_width, win_height;
    logic        dvi;
    logic [3:0]  dtypei;
    logic [15:0] datai;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [15:0] datao;
    logic [15:0] crop_rows, crop_cols;

    imager_crop #(.DATA_WIDTH(16), .DIM_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .win_x0(win_x0), .win_y0(win_y0), .win_width(win_width), .win_height(win_height),
        .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
        .crop_rows(crop_rows), .crop_cols(crop_cols)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          en;
        logic [15:0] x0, y0, w, h;
        bit          dv;
        logic [3:0]  dt;
        logic [15:0] d;
        bit          edv;
        logic [3:0]  edt;
        logic [15:0] ed;
        bit          upd;
        int          er, ec;
        bit          lit;
        int          lr, lc;
    } ent_t;

    ent_t        stim_q[$];
    ent_t        exp_q[$];
    int          n_chk, n_fail, fid, cyc, m_rows, m_cols, word_no;
    bit          drv_done;
    bit          cur_rst, cur_en;
    logic [15:0] cur_x0, cur_y0, cur_w, cur_h;

    function automatic ent_t mk(input bit dv, input logic [3:0] dt, input logic [15:0] d,
                                input bit keep, input logic [15:0] ed);
        ent_t e;
        e = '{default: 0};
        e.rst = cur_rst; e.en = cur_en;
        e.x0 = cur_x0; e.y0 = cur_y0; e.w = cur_w; e.h = cur_h;
        e.dv = dv; e.dt = dt; e.d = d;
        e.edv = dv && keep;
        e.edt = (dv && keep) ? dt : 4'd0;
        e.ed  = (dv && keep) ? ed : 16'd0;
        return e;
    endfunction

    task automatic push(input bit dv, input logic [3:0] dt, input logic [15:0] d,
                        input bit keep, input logic [15:0] ed);
        stim_q.push_back(mk(dv, dt, d, keep, ed));
    endtask

    task automatic push_gap();
        push(1'b0, `DTYPE_PIXEL, 16'h5A5A, 1'b0, 16'h0);
    endtask

    task automatic push_headers(input logic [15:0] tag);
        push(1'b1, `DTYPE_HEADER_START, 16'hC000, 1'b1, 16'hC000);
        push(1'b1, `DTYPE_HEADER, tag, 1'b1, tag);
        push(1'b1, `DTYPE_HEADER_END, 16'hC0FF, 1'b1, 16'hC0FF);
    endtask

    // Words seen between frames: headers and undefined types pass, frame content is dropped.
    task automatic idle_words();
        push_headers(16'h1234);
        push(1'b1, 4'hB, 16'hBEEF, 1'b1, 16'hBEEF);
        push(1'b1, `DTYPE_PIXEL, 16'h7777, 1'b0, 16'h0);
        push(1'b1, `DTYPE_ROW_END, 16'h7778, 1'b0, 16'h0);
        push(1'b1, `DTYPE_FRAME_END, 16'h7779, 1'b0, 16'h0);
        push_gap();
    endtask

    task automatic gen_frame(input int rows, input int cols, input bit en,
                             input int x0, input int y0, input int w, input int h,
                             input bit no_first_rs, input bit no_last_re,
                             input int chg_row, input int chg_x0, input int rst_row,
                             input int lit_rows, input int lit_cols);
        int   kept_rows, last_cols, npix;
        bit   rk, pk, abort;
        ent_t e;
        kept_rows = 0; last_cols = 0; abort = 1'b0;
        cur_en = en; cur_x0 = 16'(x0); cur_y0 = 16'(y0); cur_w = 16'(w); cur_h = 16'(h);
        fid++;
        push(1'b1, `DTYPE_FRAME_START, 16'(16'hF000 + fid), 1'b1, 16'(16'hF000 + fid));
        push_headers(16'(fid));
        for (int r = 0; r < rows; r++) begin
            if (r == chg_row) cur_x0 = 16'(chg_x0);
            if (r == rst_row) begin
                cur_rst = 1'b1;
                repeat (3) push_gap();
                cur_rst = 1'b0;
                abort = 1'b1;
                push_headers(16'h00AB);
            end
            rk = !abort && (!en || (r >= y0 && r < y0 + h && w > 0));
            if (!(r == 0 && no_first_rs))
                push(1'b1, `DTYPE_ROW_START, 16'(16'h0A00 + r), rk,
                     en ? 16'(r - y0) : 16'(16'h0A00 + r));
            npix = 0;
            for (int c = 0; c < cols; c++) begin
                pk = rk && (!en || (c >= x0 && c < x0 + w));
                push(1'b1, `DTYPE_PIXEL, 16'(16'h1000 + r * 16 + c), pk, 16'(16'h1000 + r * 16 + c));
                if (pk) npix++;
            end
            if (!(r == rows - 1 && no_last_re)) begin
                push(1'b1, `DTYPE_ROW_END, 16'(16'h0E00 + r), rk, 16'(16'h0E00 + r));
                if (rk) begin
                    kept_rows++;
                    last_cols = npix;
                end
            end
            push_gap();
        end
        e = mk(1'b1, `DTYPE_FRAME_END, 16'hFE00, !abort, 16'hFE00);
        e.upd = !abort; e.er = kept_rows; e.ec = last_cols;
        e.lit = !abort; e.lr = lit_rows; e.lc = lit_cols;
        stim_q.push_back(e);
        push_gap();
        push_gap();
    endtask

    // Driver: applies one stimulus entry per cycle on the falling edge.
    initial begin
        ent_t e;
        reset = 1'b1; enable = 1'b0; win_x0 = '0; win_y0 = '0; win_width = '0; win_height = '0;
        dvi = 1'b0; dtypei = '0; datai = '0; drv_done = 1'b0;
        fid = 0; cur_rst = 1'b1; cur_en = 1'b0;
        cur_x0 = '0; cur_y0 = '0; cur_w = '0; cur_h = '0;
        repeat (3) push_gap();
        cur_rst = 1'b0;
        idle_words();
        //        rows cols en  x0       y0       w  h  nfrs nlre chg chgx rst  lit
        gen_frame(6,   8,   1,  2,       1,       3, 2, 0,   0,   -1, 0,   -1,  2, 3);
        gen_frame(6,   8,   0,  2,       1,       3, 2, 0,   0,   -1, 0,   -1,  6, 8);
        gen_frame(6,   8,   1,  2,       1,       3, 2, 0,   0,   2,  5,   -1,  2, 3);
        gen_frame(6,   8,   1,  5,       1,       3, 2, 0,   0,   -1, 0,   -1,  2, 3);
        gen_frame(6,   8,   1,  0,       0,       8, 6, 1,   1,   -1, 0,   -1,  5, 8);
        gen_frame(6,   8,   1,  0,       0,       0, 6, 0,   0,   -1, 0,   -1,  0, 0);
        gen_frame(6,   8,   1,  'hFFFF,  0,       2, 6, 0,   0,   -1, 0,   -1,  6, 0);
        gen_frame(6,   8,   1,  0,       'hFFFF,  8, 2, 0,   0,   -1, 0,   -1,  0, 0);
        gen_frame(6,   8,   1,  2,       1,       3, 2, 0,   0,   -1, 0,   3,   0, 0);
        idle_words();
        gen_frame(6,   8,   1,  1,       4,       4, 5, 0,   0,   -1, 0,   -1,  2, 4);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            e = stim_q.pop_front();
            reset = e.rst; enable = e.en;
            win_x0 = e.x0; win_y0 = e.y0; win_width = e.w; win_height = e.h;
            dvi = e.dv; dtypei = e.dt; datai = e.d;
            exp_q.push_back(e);
        end
        @(negedge clk);
        dvi = 1'b0;
        drv_done = 1'b1;
    end

    // Checker: one expected entry per cycle, sampled 1 ns after the rising edge.
    initial begin
        ent_t e;
        n_chk = 0; n_fail = 0; cyc = 0; m_rows = 0; m_cols = 0; word_no = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                word_no++;
                if (e.rst) begin
                    m_rows = 0;
                    m_cols = 0;
                end
                if (e.upd) begin
                    m_rows = e.er;
                    m_cols = e.ec;
                end
                n_chk++;
                if (dvo !== e.edv || dtypeo !== e.edt || datao !== e.ed) begin
                    n_fail++;
                    $display("FAIL stream word %0d: got dv=%0d type=%0d data=%h, want dv=%0d type=%0d data=%h",
                             word_no, dvo, dtypeo, datao, e.edv, e.edt, e.ed);
                end
                n_chk++;
                if (crop_rows !== 16'(m_rows) || crop_cols !== 16'(m_cols)) begin
                    n_fail++;
                    $display("FAIL crop counts word %0d: got rows=%0d cols=%0d, want rows=%0d cols=%0d",
                             word_no, crop_rows, crop_cols, m_rows, m_cols);
                end
                if (e.lit) begin
                    n_chk++;
                    if (crop_rows !== 16'(e.lr) || crop_cols !== 16'(e.lc)) begin
                        n_fail++;
                        $display("FAIL frame crop word %0d: got rows=%0d cols=%0d, want rows=%0d cols=%0d",
                                 word_no, crop_rows, crop_cols, e.lr, e.lc);
                    end
                    $display("frame end word %0d: crop_rows=%0d crop_cols=%0d", word_no, crop_rows, crop_cols);
                end
            end else if (drv_done) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            if (cyc > 20000) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout: got %0d cycles, want at most 20000", cyc);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

endmodule
